// File: rtl/bitonic_sort_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bitonic_sort_sequencer
// Purpose  : Iterative full bitonic sorter. A single NUM_WAY/2-comparator
//            compare-exchange layer is reused once per cycle across all
//            bitonic stages, so one vector is sorted in
//            L*(L+1)/2 cycles (L = LOG2_NUM_WAY). The result is ascending,
//            with lane 0 holding the smallest value.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                    in   1    clock, all state on rising edge
//   rstn                   in   1    synchronous active-low reset
//   in_valid / in_ready    in/out    input handshake (accepted only in IDLE)
//   pre_sort_flatted_in    in   W*N  element g at [g*W +: W]
//   sort_desc              in   1    (BITONIC_SEQ_DESCEND_EN only) descending
//   out_valid / out_ready  out/in    output handshake (DONE state)
//   post_sort_flatted_out  out  W*N  registered sorted vector
//   busy                   out  1    high while sorting
// Configuration macro
//   BITONIC_SEQ_DESCEND_EN : adds sort_desc and a stored direction bit that
//                            inverts every compare-exchange direction.
// ============================================================================
module bitonic_sort_sequencer #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 32,
    parameter int NUM_WAY                  = 16,
    parameter int LOG2_NUM_WAY             = 4
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]   pre_sort_flatted_in,
`ifdef BITONIC_SEQ_DESCEND_EN
    input  logic                                          sort_desc,
`endif
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]   post_sort_flatted_out,
    output logic                                          busy
);

    localparam int c_W  = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int c_N  = NUM_WAY;
    localparam int c_L  = LOG2_NUM_WAY;
    // Counters hold values up to L; one spare code keeps L=1 well formed.
    localparam int c_KW = $clog2(c_L + 2);

    generate
        if ((c_L < 1) || (c_N != (1 << c_L))) begin : g_cfg_check
            $error("bitonic_sort_sequencer: NUM_WAY must equal 2**LOG2_NUM_WAY, LOG2_NUM_WAY >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_W*c_N-1:0]   data_q,  data_d;
    logic [c_KW-1:0]      k_q,     k_d;
    logic [c_KW-1:0]      j_q,     j_d;
    logic                 w_desc;
    logic                 w_last_layer;
    logic [c_W*c_N-1:0]   w_layer;

`ifdef BITONIC_SEQ_DESCEND_EN
    logic                 desc_q, desc_d;
    assign w_desc = desc_q;
`else
    assign w_desc = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // One compare-exchange layer at distance d = 2^(k-1-j). The pair direction
    // comes from bit k of the lower index; for k = L that bit is always zero,
    // so the final merge is uniformly ascending (or uniformly descending when
    // the stored direction bit inverts it).
    // ------------------------------------------------------------------------
    int               w_shift;
    int               w_dist;
    logic [c_W-1:0]   w_a, w_b, w_lo, w_hi;
    logic             w_asc;

    always_comb begin
        w_layer = data_q;
        w_a     = '0;
        w_b     = '0;
        w_lo    = '0;
        w_hi    = '0;
        w_asc   = 1'b1;
        w_shift = int'(k_q) - 1 - int'(j_q);
        // Outside the SORT state the counters may sit at values that do not
        // describe a real layer; a zero distance disables the network then.
        w_dist  = ((w_shift >= 0) && (w_shift < c_L)) ? (1 << w_shift) : 0;
        if (w_dist != 0) begin
            for (int i = 0; i < c_N; i++) begin
                if ((i & w_dist) == 0) begin
                    w_a   = data_q[i*c_W +: c_W];
                    w_b   = data_q[(i+w_dist)*c_W +: c_W];
                    w_lo  = (w_a < w_b) ? w_a : w_b;
                    w_hi  = (w_a < w_b) ? w_b : w_a;
                    w_asc = (((i >> int'(k_q)) & 1) == 0) ^ w_desc;
                    w_layer[i*c_W +: c_W]          = w_asc ? w_lo : w_hi;
                    w_layer[(i+w_dist)*c_W +: c_W] = w_asc ? w_hi : w_lo;
                end
            end
        end
    end

    assign w_last_layer = (k_q == c_KW'(c_L)) && (j_q == c_KW'(c_L - 1));

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        k_d     = k_q;
        j_d     = j_q;
`ifdef BITONIC_SEQ_DESCEND_EN
        desc_d  = desc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = pre_sort_flatted_in;
                    k_d     = c_KW'(1);
                    j_d     = '0;
`ifdef BITONIC_SEQ_DESCEND_EN
                    desc_d  = sort_desc;
`endif
                    state_d = ST_SORT;
                end
            end
            ST_SORT: begin
                data_d = w_layer;
                if (w_last_layer) begin
                    // Counters are parked at the stage-1 start value; they
                    // are reloaded on the next accepted vector anyway.
                    k_d     = c_KW'(1);
                    j_d     = '0;
                    state_d = ST_DONE;
                end else if (j_q == (k_q - c_KW'(1))) begin
                    j_d = '0;
                    k_d = k_q + c_KW'(1);
                end else begin
                    j_d = j_q + c_KW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            k_q     <= c_KW'(1);
            j_q     <= '0;
`ifdef BITONIC_SEQ_DESCEND_EN
            desc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            k_q     <= k_d;
            j_q     <= j_d;
`ifdef BITONIC_SEQ_DESCEND_EN
            desc_q  <= desc_d;
`endif
        end
    end

    assign in_ready              = (state_q == ST_IDLE);
    assign busy                  = (state_q == ST_SORT);
    assign out_valid             = (state_q == ST_DONE);
    assign post_sort_flatted_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_bitonic_sort_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bitonic_sort_sequencer
// Purpose  : Self-checking bench. A small N=4/W=8 instance and a default
//            N=16/W=32 instance are driven side by side; expected vectors
//            come from a queue-sort reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitonic_sort_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        v4, rdy4, ov4, or4, busy4;
    logic [31:0] din4, dout4;
    logic        v16, rdy16, ov16, or16, busy16;
    logic [511:0] din16, dout16;
    bit          desc4, desc16;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    bitonic_sort_sequencer #(
        .SINGLE_WAY_WIDTH_IN_BITS (8),
        .NUM_WAY                  (4),
        .LOG2_NUM_WAY             (2)
    ) u_dut4 (
        .clk                   (clk),
        .rstn                  (rstn),
        .in_valid              (v4),
        .in_ready              (rdy4),
        .pre_sort_flatted_in   (din4),
`ifdef BITONIC_SEQ_DESCEND_EN
        .sort_desc             (desc4),
`endif
        .out_valid             (ov4),
        .out_ready             (or4),
        .post_sort_flatted_out (dout4),
        .busy                  (busy4)
    );

    bitonic_sort_sequencer u_dut16 (
        .clk                   (clk),
        .rstn                  (rstn),
        .in_valid              (v16),
        .in_ready              (rdy16),
        .pre_sort_flatted_in   (din16),
`ifdef BITONIC_SEQ_DESCEND_EN
        .sort_desc             (desc16),
`endif
        .out_valid             (ov16),
        .out_ready             (or16),
        .post_sort_flatted_out (dout16),
        .busy                  (busy16)
    );

    // Reference: unpack lanes, sort the multiset, repack.
    function automatic logic [511:0] ref_sort(input logic [511:0] v, input int n,
                                              input int w, input bit desc);
        int unsigned q[$];
        logic [511:0] r;
        logic [511:0] m;
        m = (512'd1 << w) - 512'd1;
        for (int i = 0; i < n; i++) q.push_back(32'((v >> (i*w)) & m));
        if (desc) q.rsort(); else q.sort();
        r = '0;
        for (int i = 0; i < n; i++) r = r | (512'(q[i]) << (i*w));
        return r;
    endfunction

    // Presents one vector on the small instance and waits for out_valid.
    // lat = edges from the accepting edge to out_valid; busyc = SORT cycles.
    task automatic send4(input logic [31:0] vec, input bit noise,
                         output int lat, output int busyc);
        bit rdy_seen;
        @(negedge clk);
        checks++;
        if (rdy4 !== 1'b1) begin
            failures++;
            $display("FAIL send4_in_ready act=%b req=1", rdy4);
        end
        v4 = 1'b1; din4 = vec;
        @(negedge clk);
        v4 = 1'b0;
        lat = 0; busyc = 0; rdy_seen = 1'b0;
        while (ov4 !== 1'b1 && lat < 50) begin
            if (busy4 === 1'b1) busyc++;
            if (rdy4 !== 1'b0) rdy_seen = 1'b1;
            if (noise && lat == 0) begin v4 = 1'b1; din4 = $urandom; end
            else v4 = 1'b0;
            lat++;
            @(negedge clk);
        end
        v4 = 1'b0;
        checks++;
        if (rdy_seen || lat >= 50) begin
            failures++;
            $display("FAIL send4_sorting act_rdy_seen=%b act_lat=%0d req_rdy_seen=0 req_lat<50", rdy_seen, lat);
        end
    endtask

    task automatic send16(input logic [511:0] vec, output int lat);
        @(negedge clk);
        checks++;
        if (rdy16 !== 1'b1) begin
            failures++;
            $display("FAIL send16_in_ready act=%b req=1", rdy16);
        end
        v16 = 1'b1; din16 = vec;
        @(negedge clk);
        v16 = 1'b0;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 60) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy4, ov4, busy4} !== 3'b100 || dout4 !== 32'h0) begin
            failures++;
            $display("FAIL reset4 act_rdy_ov_busy=%b act_out=%h req=100/0", {rdy4, ov4, busy4}, dout4);
        end
        checks++;
        if ({rdy16, ov16, busy16} !== 3'b100 || dout16 !== 512'h0) begin
            failures++;
            $display("FAIL reset16 act_rdy_ov_busy=%b req=100 out_nonzero=%b", {rdy16, ov16, busy16}, |dout16);
        end
    endtask

    task automatic test_basic4();
        int lat, bc;
        logic [31:0] vec;
        vec = {8'h20, 8'h40, 8'h10, 8'h30};
        or4 = 1'b1;
        send4(vec, 1'b0, lat, bc);
        checks++;
        if (lat != 3 || bc != 3) begin
            failures++;
            $display("FAIL basic4_latency act_lat=%0d act_busy=%0d req=3/3", lat, bc);
        end
        checks++;
        if (dout4 !== 32'h40302010 || dout4 !== ref_sort(512'(vec), 4, 8, 1'b0)) begin
            failures++;
            $display("FAIL basic4_data act=%h req=40302010", dout4);
        end
        @(negedge clk);
        checks++;
        if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
            failures++;
            $display("FAIL basic4_return act_ov=%b act_rdy=%b req=0/1", ov4, rdy4);
        end
    endtask

    task automatic test_stall16();
        int lat;
        logic [511:0] vec, exp;
        for (int g = 0; g < 16; g++) vec[g*32 +: 32] = 32'(15 - g);
        for (int g = 0; g < 16; g++) exp[g*32 +: 32] = 32'(g);
        or16 = 1'b0;
        send16(vec, lat);
        checks++;
        if (lat != 10) begin
            failures++;
            $display("FAIL stall16_latency act=%0d req=10", lat);
        end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (ov16 !== 1'b1 || rdy16 !== 1'b0 || dout16 !== exp) begin
                failures++;
                $display("FAIL stall16_hold cycle=%0d act_ov=%b act_rdy=%b data_ok=%b req=1/0/1",
                         s, ov16, rdy16, dout16 === exp);
            end
            @(negedge clk);
        end
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        checks++;
        if (ov16 !== 1'b0 || rdy16 !== 1'b1) begin
            failures++;
            $display("FAIL stall16_return act_ov=%b act_rdy=%b req=0/1", ov16, rdy16);
        end
    endtask

    task automatic test_dup_ignore4();
        int lat, bc;
        or4 = 1'b1;
        send4(32'h00FF00FF, 1'b1, lat, bc);
        checks++;
        if (dout4 !== 32'hFFFF0000 || lat != 3) begin
            failures++;
            $display("FAIL dup4 act=%h act_lat=%0d req=ffff0000/3", dout4, lat);
        end
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b1) begin
            failures++;
            $display("FAIL dup4_no_extra_txn act_busy=%b act_rdy=%b req=0/1", busy4, rdy4);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit ov_seen;
        or4 = 1'b1;
        @(negedge clk);
        v4 = 1'b1; din4 = 32'h11223344;
        @(negedge clk);
        v4 = 1'b0;                      // first SORT cycle
        @(negedge clk);
        rstn = 1'b0;                    // second SORT cycle; handshake too
        v4 = 1'b1; din4 = 32'h55667788;
        @(negedge clk);
        rstn = 1'b1; v4 = 1'b0;
        checks++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0 || ov4 !== 1'b0 || dout4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid act_rdy=%b act_busy=%b act_ov=%b act_out=%h req=1/0/0/0",
                     rdy4, busy4, ov4, dout4);
        end
        ov_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ov4 !== 1'b0) ov_seen = 1'b1;
        end
        checks++;
        if (ov_seen) begin
            failures++;
            $display("FAIL reset_mid_no_output act=1 req=0");
        end
        send4(32'h01020304, 1'b0, lat, bc);
        checks++;
        if (dout4 !== 32'h04030201) begin
            failures++;
            $display("FAIL reset_mid_resort act=%h req=04030201", dout4);
        end
        @(negedge clk);
    endtask

    task automatic test_random16();
        int lat;
        logic [511:0] vec, exp;
        bit d;
        for (int it = 0; it < 12; it++) begin
            for (int g = 0; g < 16; g++) begin
                if (it % 3 == 0)      vec[g*32 +: 32] = $urandom_range(0, 3);
                else if (it % 3 == 1) vec[g*32 +: 32] = ($urandom % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
                else                  vec[g*32 +: 32] = $urandom;
            end
`ifdef BITONIC_SEQ_DESCEND_EN
            d = ($urandom % 2) == 1;
            desc16 = d;
`else
            d = 1'b0;
`endif
            exp = ref_sort(vec, 16, 32, d);
            or16 = 1'b0;
            send16(vec, lat);
`ifdef BITONIC_SEQ_DESCEND_EN
            desc16 = ~d;                // must not affect the running sort
`endif
            checks++;
            if (lat != 10) begin
                failures++;
                $display("FAIL random16_latency iter=%0d act=%0d req=10", it, lat);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (ov16 !== 1'b1 || dout16 !== exp) begin
                failures++;
                $display("FAIL random16_data iter=%0d act_ov=%b act_lane0=%h req_lane0=%h act_lane15=%h req_lane15=%h",
                         it, ov16, dout16[31:0], exp[31:0], dout16[511:480], exp[511:480]);
            end
            or16 = 1'b1;
            @(negedge clk);
            or16 = 1'b0;
        end
    endtask

    task automatic test_back_to_back4();
        logic [31:0] expq[$];
        int acc_t[$];
        int idx, outs, guard;
        logic [31:0] nv;
        or4 = 1'b1; idx = 0; outs = 0; guard = 0;
        while (outs < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (ov4 === 1'b1) begin
                checks++;
                if (expq.size() == 0 || dout4 !== expq[0]) begin
                    failures++;
                    $display("FAIL b2b_data out=%0d act=%h", outs, dout4);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                outs++;
            end
            if (rdy4 === 1'b1) begin
                if (idx < 4) begin
                    nv = $urandom;
                    v4 = 1'b1; din4 = nv;
                    expq.push_back(32'(ref_sort(512'(nv), 4, 8, 1'b0)));
                    acc_t.push_back(cyc);
                    idx++;
                end else begin
                    v4 = 1'b0;
                end
            end
        end
        v4 = 1'b0;
        checks++;
        if (outs != 4) begin
            failures++;
            $display("FAIL b2b_count act=%0d req=4", outs);
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++;
            if (acc_t[i] - acc_t[i-1] != 5) begin
                failures++;
                $display("FAIL b2b_interval idx=%0d act=%0d req=5", i, acc_t[i] - acc_t[i-1]);
            end
        end
    endtask

`ifdef BITONIC_SEQ_DESCEND_EN
    task automatic test_descend4();
        int lat, bc;
        or4 = 1'b1;
        desc4 = 1'b1;
        send4(32'h30204010, 1'b0, lat, bc);
        checks++;
        if (dout4 !== 32'h10203040 || lat != 3) begin
            failures++;
            $display("FAIL descend4 act=%h act_lat=%0d req=10203040/3", dout4, lat);
        end
        desc4 = 1'b0;
        send4(32'h30204010, 1'b0, lat, bc);
        checks++;
        if (dout4 !== 32'h40302010) begin
            failures++;
            $display("FAIL descend4_back_to_asc act=%h req=40302010", dout4);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rstn = 1'b0;
        v4 = 1'b0; or4 = 1'b0; din4 = '0; desc4 = 1'b0;
        v16 = 1'b0; or16 = 1'b0; din16 = '0; desc16 = 1'b0;
        test_reset();
        test_basic4();
        test_stall16();
        test_dup_ignore4();
        test_reset_mid();
        test_random16();
        test_back_to_back4();
`ifdef BITONIC_SEQ_DESCEND_EN
        test_descend4();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
